piso_shift_tx: RTL
==================

// Module: piso_shift_tx
// PURPOSE
//  Parallel-in serial-out transmitter: accepts a WIDTH-bit word on a valid/ready
//  load handshake, then drives it one bit per CLK on ser_out with a frame qualifier.
//  Sending end of the serial bit stream captured by the d_ff-based SIPO receive chain.
//  Sits between a word producer and a single-wire serial link; one word in flight.
// PARAMETERS
//  WIDTH      8   word width in bits; legal range >= 2
//  MSB_FIRST  1   1: bit WIDTH-1 sent first; 0: bit 0 sent first
// PORTS
//  CLK         in   1      clock, all state changes on rising edge
//  n_res       in   1      asynchronous active-low reset
//  data_in     in   WIDTH  word to transmit, sampled only on accepted load
//  load_valid  in   1      producer offers data_in this cycle
//  load_ready  out  1      transmitter can accept a word (registered)
//  ser_out     out  1      serial data bit (registered)
//  frame       out  1      high while ser_out carries a valid data bit
//  done        out  1      one-cycle pulse after the last bit of a word
// BEHAVIOUR
//  - One clock (CLK, rising edge); reset n_res asynchronous, active-low.
//  - Reset (n_res=0, takes effect immediately, no clock needed): state=IDLE,
//    load_ready=1, ser_out=0, frame=0, done=0, shift reg=0, bit count=0.
//  - All outputs are registered; no combinational path from inputs to outputs.
//  - States: IDLE, SHIFT, DONE.
//  - IDLE: load_ready=1, frame=0, ser_out=0. Edge with load_valid=1: capture
//    data_in, drive first bit on ser_out, frame<=1, load_ready<=0, count<=WIDTH-1,
//    go SHIFT. load_valid=0: stay IDLE.
//  - SHIFT: each edge presents next bit, count decrements. Edge with count==0:
//    frame<=0, ser_out<=0, done<=1, go DONE. frame high exactly WIDTH cycles.
//  - DONE: one cycle; next edge done<=0, load_ready<=1, go IDLE.
//  - Timing: accept at edge 0 -> bits on cycles 1..WIDTH, done high cycle WIDTH+1,
//    load_ready high from cycle WIDTH+2. Min word period WIDTH+2 cycles.
//  - load_valid in SHIFT/DONE ignored (no accept, no queueing); data_in changes
//    after capture do not affect the word in flight.
//  - Bit order: MSB_FIRST=1 -> data[WIDTH-1] first; MSB_FIRST=0 -> data[0] first.
//  - Bit counter width $clog2(WIDTH); no wrap beyond 0 (leaves SHIFT at 0).
//  - Reset mid-SHIFT or in DONE: word dropped, frame/done clear at once, no done
//    pulse; after release, IDLE with load_ready=1 on the first edge.
//  - X on load_valid in IDLE is a protocol error; no defined recovery.
// TESTING (drive inputs on negedge CLK, check outputs 11ps after posedge)
//  1. Reset: n_res=0 mid-cycle -> within 11ps load_ready=1, frame=0, done=0,
//     ser_out=0, no CLK edge needed.
//  2. WIDTH=8, MSB_FIRST=1, load 8'hA5 -> ser_out 1,0,1,0,0,1,0,1 on cycles 1..8,
//     frame=1 those 8 cycles, done=1 cycle 9 only, load_ready=1 from cycle 10.
//  3. MSB_FIRST=0, load 8'h01 -> ser_out 1,0,0,0,0,0,0,0; done on cycle 9.
//  4. Hold load_valid=1, data_in changing to 8'hFF during SHIFT of 8'h3C ->
//     ser_out 0,0,1,1,1,1,0,0 unchanged; 8'hFF accepted only at cycle 10 edge.
//  5. Reset pulse (15ps) during bit 4 of 8'hA5 -> frame=0 at once, no done pulse;
//     new load 8'h5A after release transmits 0,1,0,1,1,0,1,0 cleanly.
//  6. load_valid=0 for 20 cycles after reset -> frame=0, done=0, load_ready=1.

Source files
------------

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter: takes one word on a valid/ready load
// handshake and sends it one bit per clock with a frame qualifier.
`timescale 1ps/1ps
module piso_shift_tx #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             CLK,
   input  logic             n_res,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             ser_out,
   output logic             frame,
   output logic             done
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] shreg, shreg_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic             ser_nxt, frame_nxt, done_nxt, ready_nxt;

   // Bit that leaves the word first, and the word with that bit consumed.
   function automatic logic head(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? w[WIDTH-1] : w[0];
   endfunction

   function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? (w << 1) : (w >> 1);
   endfunction

   // State and registered outputs.
   always_ff @(posedge CLK or negedge n_res) begin
      if (!n_res) begin
         state      <= S_IDLE;
         shreg      <= '0;
         cnt        <= '0;
         ser_out    <= 1'b0;
         frame      <= 1'b0;
         done       <= 1'b0;
         load_ready <= 1'b1;
      end else begin
         state      <= state_nxt;
         shreg      <= shreg_nxt;
         cnt        <= cnt_nxt;
         ser_out    <= ser_nxt;
         frame      <= frame_nxt;
         done       <= done_nxt;
         load_ready <= ready_nxt;
      end
   end

   // Next state and next output values; the first bit goes out on the accept edge.
   always_comb begin
      state_nxt = state;
      shreg_nxt = shreg;
      cnt_nxt   = cnt;
      ser_nxt   = 1'b0;
      frame_nxt = 1'b0;
      done_nxt  = 1'b0;
      ready_nxt = 1'b0;
      case (state)
         S_IDLE: begin
            if (load_valid) begin
               shreg_nxt = advance(data_in);
               ser_nxt   = head(data_in);
               frame_nxt = 1'b1;
               cnt_nxt   = CNT_LAST;
               state_nxt = S_SHIFT;
            end else begin
               ready_nxt = 1'b1;
            end
         end
         S_SHIFT: begin
            if (cnt == '0) begin
               shreg_nxt = '0;
               done_nxt  = 1'b1;
               state_nxt = S_DONE;
            end else begin
               ser_nxt   = head(shreg);
               shreg_nxt = advance(shreg);
               cnt_nxt   = cnt - CW'(1);
               frame_nxt = 1'b1;
            end
         end
         S_DONE: begin
            ready_nxt = 1'b1;
            state_nxt = S_IDLE;
         end
         default: begin
            ready_nxt = 1'b1;
            state_nxt = S_IDLE;
         end
      endcase
   end

endmodule
